// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: resolves per-stage stall/flush requests into hold/bubble
// controls, defers flushes blocked by older stalls, and tracks stall/flush statistics.
module pipe_hazard_ctrl #(
  parameter int          NSTAGE  = 6,
  parameter int          CNT_W   = 32,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic [NSTAGE-1:0] stall_req,
  input  logic [NSTAGE-1:0] flush_req,
  output logic [NSTAGE-1:0] stall_sign,
  output logic [NSTAGE-1:0] flush_sign,
  output logic              flush_pend_o,
  output logic [CNT_W-1:0]  stall_cnt_o,
  output logic [CNT_W-1:0]  flush_cnt_o,
  output logic              hang_o
);

  localparam int               IDX_W   = (NSTAGE > 1) ? $clog2(NSTAGE) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] TO_CNT  = CNT_W'(TIMEOUT);

  logic [IDX_W-1:0] pend_idx;
  logic [CNT_W-1:0] consec;
  logic [CNT_W-1:0] consec_inc;
  int               s_top;
  int               f_top;
  logic             issue;
  logic             defer;
  logic             stall_active;

  // s_top / f_top of -1 mean no request; keeps the mask compares uniform
  always_comb begin
    s_top = -1;
    f_top = -1;
    for (int i = 0; i < NSTAGE; i++) begin
      if (stall_req[i]) s_top = i;
      if (i > 0 && flush_req[i]) f_top = i;
    end
    if (flush_pend_o && int'(pend_idx) > f_top) f_top = int'(pend_idx);

    stall_sign = '0;
    flush_sign = '0;
    issue      = 1'b0;
    defer      = 1'b0;
    if (!rst) begin
      if (!rdy) begin
        stall_sign = '1;
        defer      = (f_top >= 0);
      end else if (f_top >= 0 && s_top < f_top) begin
        issue = 1'b1;
        for (int i = 0; i < NSTAGE; i++) flush_sign[i] = (i < f_top);
      end else begin
        for (int i = 0; i < NSTAGE; i++) stall_sign[i] = (i <= s_top);
        defer = (f_top >= 0);
      end
    end
  end

  assign stall_active = |stall_sign;
  assign consec_inc   = (consec == CNT_MAX) ? consec : consec + 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      flush_pend_o <= 1'b0;
      pend_idx     <= '0;
      stall_cnt_o  <= '0;
      flush_cnt_o  <= '0;
      consec       <= '0;
      hang_o       <= 1'b0;
    end else begin
      // f_top already folds in the old pending index, so a capture keeps the max
      if (defer) begin
        flush_pend_o <= 1'b1;
        pend_idx     <= IDX_W'(f_top);
      end else if (issue) begin
        flush_pend_o <= 1'b0;
        pend_idx     <= '0;
      end

      if (issue && flush_cnt_o != CNT_MAX) flush_cnt_o <= flush_cnt_o + 1'b1;

      if (rdy) begin
        if (stall_active) begin
          if (stall_cnt_o != CNT_MAX) stall_cnt_o <= stall_cnt_o + 1'b1;
          consec <= consec_inc;
          if (consec_inc >= TO_CNT) hang_o <= 1'b1;
        end else begin
          consec <= '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: directed vectors with literal expectations plus a
// per-cycle comparison against a priority/arithmetic reference model.
module tb_pipe_hazard_ctrl;

  localparam int N  = 6;
  localparam int TO = 16;

  logic         clk;
  logic         rst, rdy;
  logic [N-1:0] stall_req, flush_req;
  logic [N-1:0] stall_sign, flush_sign;
  logic         flush_pend_o;
  logic [31:0]  stall_cnt_o, flush_cnt_o;
  logic         hang_o;

  int  n_cmp = 0;
  int  n_bad = 0;
  bit  chk_en = 0;

  // reference model state: m_pend = -1 when nothing is deferred
  int     m_pend = -1;
  longint m_scnt = 0, m_fcnt = 0, m_consec = 0;
  bit     m_hang = 0;
  localparam longint MAXC = 64'hFFFF_FFFF;

  pipe_hazard_ctrl #(.NSTAGE(N), .CNT_W(32), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .rdy(rdy),
    .stall_req(stall_req), .flush_req(flush_req),
    .stall_sign(stall_sign), .flush_sign(flush_sign),
    .flush_pend_o(flush_pend_o), .stall_cnt_o(stall_cnt_o),
    .flush_cnt_o(flush_cnt_o), .hang_o(hang_o)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  function automatic void model_comb(input logic r, input logic rd,
                                     input logic [N-1:0] st, input logic [N-1:0] fl,
                                     input int pend,
                                     output logic [N-1:0] es, output logic [N-1:0] ef,
                                     output int cap, output bit iss);
    int s = -1;
    int f = -1;
    es = '0; ef = '0; cap = -1; iss = 0;
    for (int i = 0; i < N; i++) begin
      if (st[i]) s = i;
      if (i > 0 && fl[i]) f = i;
    end
    if (pend > f) f = pend;
    if (r) return;
    if (!rd) begin
      es = '1;
      cap = f;
    end else if (f >= 0 && s < f) begin
      ef = N'((1 << f) - 1);
      iss = 1;
    end else begin
      es = N'((1 << (s + 1)) - 1);
      cap = f;
    end
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin : model_upd
    logic [N-1:0] es, ef;
    int cap;
    bit iss;
    model_comb(rst, rdy, stall_req, flush_req, m_pend, es, ef, cap, iss);
    if (rst) begin
      m_pend = -1; m_scnt = 0; m_fcnt = 0; m_consec = 0; m_hang = 0;
    end else begin
      if (iss) begin
        m_pend = -1;
        if (m_fcnt < MAXC) m_fcnt++;
      end
      if (cap >= 0) m_pend = cap;
      if (rdy) begin
        if (es != 0) begin
          if (m_scnt < MAXC) m_scnt++;
          m_consec++;
          if (m_consec >= TO) m_hang = 1;
        end else begin
          m_consec = 0;
        end
      end
    end
  end

  always @(negedge clk) begin : cmp
    logic [N-1:0] es, ef;
    int cap;
    bit iss;
    if (chk_en) begin
      model_comb(rst, rdy, stall_req, flush_req, m_pend, es, ef, cap, iss);
      chk("m_stall_sign", stall_sign, es);
      chk("m_flush_sign", flush_sign, ef);
      chk("m_no_overlap", stall_sign & flush_sign, 0);
      chk("m_flush_pend", flush_pend_o, (m_pend >= 0));
      chk("m_stall_cnt", stall_cnt_o, m_scnt);
      chk("m_flush_cnt", flush_cnt_o, m_fcnt);
      chk("m_hang", hang_o, m_hang);
    end
  end

  task automatic cyc(input logic r, input logic rd, input logic [N-1:0] st, input logic [N-1:0] fl);
    @(posedge clk);
    #1;
    rst = r; rdy = rd; stall_req = st; flush_req = fl;
    @(negedge clk);
  endtask

  task automatic idle();
    cyc(0, 1, '0, '0);
  endtask

  initial begin
    rst = 1; rdy = 1; stall_req = '0; flush_req = '0;
    chk_en = 1;

    // reset masks outputs regardless of requests
    cyc(1, 1, 6'h3f, 6'h3f);
    chk("rst_stall", stall_sign, 0);
    chk("rst_flush", flush_sign, 0);
    cyc(1, 0, 6'h3f, 6'h3f);
    chk("rst_stall_nrdy", stall_sign, 0);
    idle();
    chk("rst_pend", flush_pend_o, 0);
    chk("rst_scnt", stall_cnt_o, 0);
    chk("rst_fcnt", flush_cnt_o, 0);
    chk("rst_hang", hang_o, 0);

    // basic stall
    cyc(0, 1, 6'b000100, 6'b000000);
    chk("r32_stall", stall_sign, 6'b000111);
    chk("r32_flush", flush_sign, 0);
    idle();
    chk("r32_scnt", stall_cnt_o, 1);

    // flush beats younger stall
    cyc(0, 1, 6'b000010, 6'b001000);
    chk("r33_flush", flush_sign, 6'b000111);
    chk("r33_stall", stall_sign, 0);
    idle();
    chk("r33_fcnt", flush_cnt_o, 1);
    chk("r33_pend", flush_pend_o, 0);

    // flush deferred behind older stall
    cyc(0, 1, 6'b010000, 6'b001000);
    chk("r34_stall0", stall_sign, 6'b011111);
    chk("r34_flush0", flush_sign, 0);
    cyc(0, 1, 6'b010000, 6'b000000);
    chk("r34_stall1", stall_sign, 6'b011111);
    chk("r34_pend1", flush_pend_o, 1);
    cyc(0, 1, 6'b010000, 6'b000000);
    chk("r34_stall2", stall_sign, 6'b011111);
    idle();
    chk("r34_flush", flush_sign, 6'b000111);
    chk("r34_stall3", stall_sign, 0);
    idle();
    chk("r34_pend", flush_pend_o, 0);
    chk("r34_fcnt", flush_cnt_o, 2);
    chk("r34_scnt", stall_cnt_o, 4);

    // flush captured while frozen, issued on first ready cycle
    cyc(0, 0, 6'b000000, 6'b000100);
    chk("r35_stall0", stall_sign, 6'b111111);
    chk("r35_flush0", flush_sign, 0);
    cyc(0, 0, 6'b000000, 6'b000000);
    chk("r35_stall1", stall_sign, 6'b111111);
    chk("r35_scnt", stall_cnt_o, 4);
    chk("r35_pend", flush_pend_o, 1);
    idle();
    chk("r35_flush", flush_sign, 6'b000011);
    chk("r35_scnt2", stall_cnt_o, 4);
    idle();
    chk("r35_fcnt", flush_cnt_o, 3);

    // stage-0 flush request has no effect
    cyc(0, 1, 6'b000000, 6'b000001);
    chk("b0_flush", flush_sign, 0);
    chk("b0_stall", stall_sign, 0);
    idle();
    chk("b0_fcnt", flush_cnt_o, 3);

    // stall at same stage as flush defers it
    cyc(0, 1, 6'b000100, 6'b000100);
    chk("eq_stall", stall_sign, 6'b000111);
    chk("eq_flush", flush_sign, 0);
    idle();
    chk("eq_flush2", flush_sign, 6'b000011);
    idle();
    chk("eq_fcnt", flush_cnt_o, 4);
    chk("eq_scnt", stall_cnt_o, 5);

    // pending merge keeps the oldest index, in either arrival order
    cyc(0, 0, 6'b000000, 6'b000100);
    cyc(0, 0, 6'b000000, 6'b010000);
    idle();
    chk("mrg_up", flush_sign, 6'b001111);
    cyc(0, 0, 6'b000000, 6'b010000);
    cyc(0, 0, 6'b000000, 6'b000100);
    idle();
    chk("mrg_dn", flush_sign, 6'b001111);
    idle();
    chk("mrg_fcnt", flush_cnt_o, 6);

    // an idle ready cycle breaks the consecutive-stall run
    cyc(1, 1, '0, '0);
    for (int i = 0; i < 10; i++) cyc(0, 1, 6'b100000, 6'b000000);
    idle();
    for (int i = 0; i < 10; i++) cyc(0, 1, 6'b100000, 6'b000000);
    idle();
    chk("gap_hang", hang_o, 0);
    chk("gap_scnt", stall_cnt_o, 20);

    // frozen cycles neither extend nor break the run
    for (int i = 0; i < 15; i++) cyc(0, 1, 6'b100000, 6'b000000);
    cyc(0, 0, 6'b000000, 6'b000000);
    cyc(0, 1, 6'b100000, 6'b000000);
    chk("frz_hang_pre", hang_o, 0);
    idle();
    chk("frz_hang", hang_o, 1);
    chk("frz_scnt", stall_cnt_o, 36);

    // hang after exactly TIMEOUT stalled cycles, sticky until reset
    cyc(1, 1, '0, '0);
    for (int i = 0; i < TO; i++) begin
      cyc(0, 1, 6'b100000, 6'b000000);
      if (i == TO - 1) chk("r36_hang_pre", hang_o, 0);
    end
    idle();
    chk("r36_hang", hang_o, 1);
    chk("r36_scnt", stall_cnt_o, 16);
    idle();
    chk("r36_hang_sticky", hang_o, 1);
    cyc(1, 1, '0, '0);
    idle();
    chk("r36_rst_hang", hang_o, 0);
    chk("r36_rst_scnt", stall_cnt_o, 0);
    chk("r36_rst_fcnt", flush_cnt_o, 0);
    chk("r36_rst_pend", flush_pend_o, 0);

    // reset discards a deferred flush
    cyc(0, 1, 6'b100000, 6'b010000);
    chk("r37_stall", stall_sign, 6'b111111);
    cyc(1, 1, '0, '0);
    chk("r37_pend_pre", flush_pend_o, 1);
    chk("r37_flush_rst", flush_sign, 0);
    idle();
    chk("r37_pend", flush_pend_o, 0);
    chk("r37_flush", flush_sign, 0);
    idle();
    chk("r37_flush2", flush_sign, 0);

    // mixed traffic, checked by the model every cycle
    for (int i = 0; i < 400; i++) begin
      logic r, rd;
      logic [N-1:0] st, fl;
      r  = ($urandom_range(0, 59) == 0);
      rd = ($urandom_range(0, 4) != 0);
      st = ($urandom_range(0, 2) == 0) ? N'($urandom) & N'($urandom) : '0;
      fl = ($urandom_range(0, 3) == 0) ? N'(1 << $urandom_range(0, N - 1)) : '0;
      cyc(r, rd, st, fl);
    end
    idle();
    idle();

    chk_en = 0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
